// File: rtl/b16_pkg.sv
// Shared constants for the b16 memory subsystem: port widths and the read-return tag.
package b16_pkg;

  localparam int unsigned AddrWDef = 16;
  localparam int unsigned DataWDef = 16;
  localparam int unsigned WrW      = 2;

  // Which port owns the read data arriving on mem_rdata this cycle.
  typedef enum logic [1:0] {
    RetNone = 2'd0,
    RetCpu  = 2'd1,
    RetDbg  = 2'd2
  } ret_tag_e;

endpackage

// File: rtl/dbg_pend_buf.sv
// One-entry buffer for debug strobes, with a sticky overflow flag for strobes
// that arrive while the entry is still occupied.
module dbg_pend_buf
  import b16_pkg::*;
#(
  parameter int unsigned AW = AddrWDef,
  parameter int unsigned DW = DataWDef
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           dbg_cs,
  input  logic [AW-1:0]  dbg_addr,
  input  logic           dbg_r,
  input  logic [WrW-1:0] dbg_wr,
  input  logic [DW-1:0]  dbg_wdata,
  input  logic           pop,
  output logic           pend_v,
  output logic [AW-1:0]  pend_addr,
  output logic           pend_r,
  output logic [WrW-1:0] pend_wr,
  output logic [DW-1:0]  pend_wdata,
  output logic           ovf
);

  logic           pend_v_q;
  logic [AW-1:0]  addr_q;
  logic           r_q;
  logic [WrW-1:0] wr_q;
  logic [DW-1:0]  wdata_q;
  logic           ovf_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pend_v_q <= 1'b0;
      addr_q   <= '0;
      r_q      <= 1'b0;
      wr_q     <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (dbg_cs && !pend_v_q) begin
        pend_v_q <= 1'b1;
        addr_q   <= dbg_addr;
        r_q      <= dbg_r;
        wr_q     <= dbg_wr;
        wdata_q  <= dbg_wdata;
      end else if (pop) begin
        pend_v_q <= 1'b0;
      end
      // A strobe is dropped even in the cycle the entry is being granted.
      if (dbg_cs && pend_v_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign pend_v     = pend_v_q;
  assign pend_addr  = addr_q;
  assign pend_r     = r_q;
  assign pend_wr    = wr_q;
  assign pend_wdata = wdata_q;
  assign ovf        = ovf_q;

endmodule

// File: rtl/mem_arb.sv
// Two-port memory arbiter: CPU and buffered debug requests share one memory port,
// round-robin on contention, with pipelined one-cycle read returns.
module mem_arb
  import b16_pkg::*;
#(
  parameter int unsigned AW = AddrWDef,
  parameter int unsigned DW = DataWDef
) (
  input  logic           clk,
  input  logic           nreset,
  // CPU port
  input  logic           cpu_cs,
  input  logic [AW-1:0]  cpu_addr,
  input  logic           cpu_r,
  input  logic [WrW-1:0] cpu_wr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_ready,
  // Debug port
  input  logic           dbg_cs,
  input  logic [AW-1:0]  dbg_addr,
  input  logic           dbg_r,
  input  logic [WrW-1:0] dbg_wr,
  input  logic [DW-1:0]  dbg_wdata,
  output logic [DW-1:0]  dbg_rdata,
  output logic           dbg_rvalid,
  output logic           dbg_busy,
  output logic           dbg_ovf,
  // Memory port
  output logic           mem_cs,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_r,
  output logic [WrW-1:0] mem_wr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);

  logic           pend_v;
  logic [AW-1:0]  pend_addr;
  logic           pend_r;
  logic [WrW-1:0] pend_wr;
  logic [DW-1:0]  pend_wdata;

  logic           cpu_inflight;
  logic           cpu_req, dbg_req;
  logic           gnt_cpu, gnt_dbg;
  logic           prefer_dbg_q;
  ret_tag_e       ret_q, ret_d;
  logic           dbg_rvalid_q;
  logic [DW-1:0]  dbg_rdata_q;

  dbg_pend_buf #(
    .AW(AW),
    .DW(DW)
  ) u_pend (
    .clk       (clk),
    .nreset    (nreset),
    .dbg_cs    (dbg_cs),
    .dbg_addr  (dbg_addr),
    .dbg_r     (dbg_r),
    .dbg_wr    (dbg_wr),
    .dbg_wdata (dbg_wdata),
    .pop       (gnt_dbg),
    .pend_v    (pend_v),
    .pend_addr (pend_addr),
    .pend_r    (pend_r),
    .pend_wr   (pend_wr),
    .pend_wdata(pend_wdata),
    .ovf       (dbg_ovf)
  );

  // A granted CPU read is awaiting data exactly when the return tag says CPU.
  assign cpu_inflight = (ret_q == RetCpu);
  // Requests are masked during reset so the memory port stays quiet.
  assign cpu_req      = nreset && cpu_cs && !cpu_inflight;
  assign dbg_req      = nreset && pend_v;

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      gnt_dbg = prefer_dbg_q;
      gnt_cpu = !prefer_dbg_q;
    end else begin
      gnt_cpu = cpu_req;
      gnt_dbg = dbg_req;
    end
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_addr  = '0;
    mem_r     = 1'b0;
    mem_wr    = '0;
    mem_wdata = '0;
    ret_d     = RetNone;
    if (gnt_cpu) begin
      mem_cs    = 1'b1;
      mem_addr  = cpu_addr;
      mem_r     = cpu_r;
      mem_wr    = cpu_r ? '0 : cpu_wr;
      mem_wdata = cpu_wdata;
      ret_d     = cpu_r ? RetCpu : RetNone;
    end else if (gnt_dbg) begin
      mem_cs    = 1'b1;
      mem_addr  = pend_addr;
      mem_r     = pend_r;
      mem_wr    = pend_r ? '0 : pend_wr;
      mem_wdata = pend_wdata;
      ret_d     = pend_r ? RetDbg : RetNone;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ret_q        <= RetNone;
      prefer_dbg_q <= 1'b1;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      ret_q        <= ret_d;
      dbg_rvalid_q <= (ret_q == RetDbg);
      if (cpu_req && dbg_req) begin
        prefer_dbg_q <= gnt_cpu;
      end
      if (ret_q == RetDbg) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Read data for a CPU that dropped cpu_cs is discarded by withholding ready.
  assign cpu_ready  = (gnt_cpu && !cpu_r) || (nreset && cpu_inflight && cpu_cs);
  assign cpu_rdata  = (nreset && cpu_inflight) ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_busy   = pend_v;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a one-cycle-latency memory model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cpu_cs, cpu_r, dbg_cs, dbg_r;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [1:0]  cpu_wr, dbg_wr, mem_wr;
  logic        cpu_ready, dbg_rvalid, dbg_busy, dbg_ovf, mem_cs, mem_r;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb #(.AW(16), .DW(16)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_cs(dbg_cs), .dbg_addr(dbg_addr), .dbg_r(dbg_r), .dbg_wr(dbg_wr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .dbg_busy(dbg_busy), .dbg_ovf(dbg_ovf),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_r(mem_r), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] model(input logic [15:0] a);
    case (a)
      16'h0010: model = 16'h5A5A;
      16'h0002: model = 16'h1111;
      16'h0004: model = 16'h2222;
      default:  model = a ^ 16'hC3C3;
    endcase
  endfunction

  // Memory: read data valid exactly one cycle after a mem_r cycle.
  always @(posedge clk) mem_rdata <= (mem_cs && mem_r) ? model(mem_addr) : 16'h0000;

  // Inputs change 1 time unit after the edge; checks run 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_cs = 0; cpu_r = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_cs = 0; dbg_r = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic apply_reset();
    next_cycle(); idle(); nreset = 0;
    next_cycle(); nreset = 1;
  endtask

  task automatic test_reset();
    idle(); nreset = 0;
    cpu_cs = 1; cpu_wr = 2'b11; cpu_addr = 16'h1111;
    next_cycle(); next_cycle(); #2;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rst_mem_cs got %0h exp 0", mem_cs); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %0h exp 0", cpu_ready); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (dbg_busy !== 1'b0) begin errors++; $display("FAIL rst_dbg_busy got %0h exp 0", dbg_busy); end
    checks++; if (dbg_ovf !== 1'b0) begin errors++; $display("FAIL rst_dbg_ovf got %0h exp 0", dbg_ovf); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dbg_rvalid got %0h exp 0", dbg_rvalid); end
    checks++; if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL rst_dbg_rdata got %0h exp 0", dbg_rdata); end
    next_cycle(); idle(); nreset = 1;
  endtask

  task automatic test_cpu_write();
    cpu_cs = 1; cpu_addr = 16'h1234; cpu_r = 0; cpu_wr = 2'b11; cpu_wdata = 16'hBEEF;
    #2;
    checks++; if (mem_cs !== 1'b1) begin errors++; $display("FAIL wr_mem_cs got %0h exp 1", mem_cs); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL wr_mem_addr got %0h exp 1234", mem_addr); end
    checks++; if (mem_wr !== 2'b11) begin errors++; $display("FAIL wr_mem_wr got %0h exp 3", mem_wr); end
    checks++; if (mem_r !== 1'b0) begin errors++; $display("FAIL wr_mem_r got %0h exp 0", mem_r); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_wdata got %0h exp beef", mem_wdata); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_cpu_ready got %0h exp 1", cpu_ready); end
    next_cycle(); idle(); #2;
    checks++; if (mem_cs !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL wr_idle_mem got cs %0h addr %0h exp 0 0", mem_cs, mem_addr); end
  endtask

  task automatic test_dbg_read();
    dbg_cs = 1; dbg_addr = 16'h0010; dbg_r = 1; dbg_wr = 2'b11;
    #2;
    checks++; if (dbg_busy !== 1'b0 || mem_cs !== 1'b0) begin errors++; $display("FAIL dr_strobe got busy %0h cs %0h exp 0 0", dbg_busy, mem_cs); end
    next_cycle(); idle(); #2;
    checks++; if (dbg_busy !== 1'b1) begin errors++; $display("FAIL dr_busy got %0h exp 1", dbg_busy); end
    checks++; if (mem_cs !== 1'b1 || mem_r !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL dr_grant got cs %0h r %0h addr %0h exp 1 1 0010", mem_cs, mem_r, mem_addr); end
    checks++; if (mem_wr !== 2'b00) begin errors++; $display("FAIL dr_wr_forced got %0h exp 0", mem_wr); end
    next_cycle(); #2;
    checks++; if (dbg_busy !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL dr_wait got busy %0h rvalid %0h exp 0 0", dbg_busy, dbg_rvalid); end
    next_cycle(); #2;
    checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL dr_rvalid got %0h exp 1", dbg_rvalid); end
    checks++; if (dbg_rdata !== 16'h5A5A) begin errors++; $display("FAIL dr_rdata got %0h exp 5a5a", dbg_rdata); end
    next_cycle(); #2;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 16'h5A5A) begin errors++; $display("FAIL dr_hold got rvalid %0h rdata %0h exp 0 5a5a", dbg_rvalid, dbg_rdata); end
  endtask

  task automatic test_contest();
    apply_reset();
    dbg_cs = 1; dbg_addr = 16'h0020; dbg_r = 0; dbg_wr = 2'b01; dbg_wdata = 16'hAAAA;
    next_cycle(); idle();
    cpu_cs = 1; cpu_r = 1; cpu_addr = 16'h0030; #2;
    checks++; if (mem_addr !== 16'h0020 || mem_wr !== 2'b01 || mem_r !== 1'b0) begin errors++; $display("FAIL ct_dbg_first got addr %0h wr %0h r %0h exp 0020 1 0", mem_addr, mem_wr, mem_r); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL ct_cpu_wait got %0h exp 0", cpu_ready); end
    next_cycle(); #2;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 16'h0030 || mem_r !== 1'b1) begin errors++; $display("FAIL ct_cpu_grant got cs %0h addr %0h r %0h exp 1 0030 1", mem_cs, mem_addr, mem_r); end
    checks++; if (cpu_ready !== 1'b0 || dbg_busy !== 1'b0) begin errors++; $display("FAIL ct_cpu_grant_rdy got rdy %0h busy %0h exp 0 0", cpu_ready, dbg_busy); end
    next_cycle(); #2;
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hC3F3) begin errors++; $display("FAIL ct_cpu_data got rdy %0h data %0h exp 1 c3f3", cpu_ready, cpu_rdata); end
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL ct_no_regrant got %0h exp 0", mem_cs); end
    next_cycle(); idle();
    dbg_cs = 1; dbg_addr = 16'h0040; dbg_wr = 2'b10;
    next_cycle(); idle();
    cpu_cs = 1; cpu_addr = 16'h0050; cpu_wr = 2'b11; #2;
    checks++; if (mem_addr !== 16'h0050 || cpu_ready !== 1'b1) begin errors++; $display("FAIL ct_second_cpu got addr %0h rdy %0h exp 0050 1", mem_addr, cpu_ready); end
    next_cycle(); idle(); #2;
    checks++; if (mem_addr !== 16'h0040 || mem_wr !== 2'b10) begin errors++; $display("FAIL ct_second_dbg got addr %0h wr %0h exp 0040 2", mem_addr, mem_wr); end
    next_cycle(); idle();
  endtask

  task automatic test_ovf();
    dbg_cs = 1; dbg_addr = 16'h0060; dbg_wr = 2'b11;
    cpu_cs = 1; cpu_addr = 16'h0070; cpu_wr = 2'b11;
    next_cycle();
    dbg_addr = 16'h0066; #2;
    checks++; if (dbg_busy !== 1'b1 || dbg_ovf !== 1'b0) begin errors++; $display("FAIL ov_first got busy %0h ovf %0h exp 1 0", dbg_busy, dbg_ovf); end
    checks++; if (mem_addr !== 16'h0060) begin errors++; $display("FAIL ov_dbg_grant got %0h exp 0060", mem_addr); end
    next_cycle(); dbg_cs = 0; #2;
    checks++; if (dbg_ovf !== 1'b1 || dbg_busy !== 1'b0) begin errors++; $display("FAIL ov_dropped got ovf %0h busy %0h exp 1 0", dbg_ovf, dbg_busy); end
    next_cycle(); idle(); next_cycle(); #2;
    checks++; if (dbg_ovf !== 1'b1 || mem_cs !== 1'b0) begin errors++; $display("FAIL ov_sticky got ovf %0h cs %0h exp 1 0", dbg_ovf, mem_cs); end
  endtask

  task automatic test_back_to_back();
    cpu_cs = 1; cpu_r = 1; cpu_addr = 16'h0002;
    dbg_cs = 1; dbg_r = 1; dbg_addr = 16'h0004; #2;
    checks++; if (mem_r !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL bb_cpu_grant got r %0h addr %0h exp 1 0002", mem_r, mem_addr); end
    next_cycle(); dbg_cs = 0; #2;
    checks++; if (mem_r !== 1'b1 || mem_addr !== 16'h0004) begin errors++; $display("FAIL bb_dbg_grant got r %0h addr %0h exp 1 0004", mem_r, mem_addr); end
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h1111) begin errors++; $display("FAIL bb_cpu_data got rdy %0h data %0h exp 1 1111", cpu_ready, cpu_rdata); end
    next_cycle(); idle(); #2;
    checks++; if (cpu_ready !== 1'b0 || dbg_rvalid !== 1'b0 || mem_cs !== 1'b0) begin errors++; $display("FAIL bb_gap got rdy %0h rv %0h cs %0h exp 0 0 0", cpu_ready, dbg_rvalid, mem_cs); end
    next_cycle(); #2;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h2222) begin errors++; $display("FAIL bb_dbg_data got rv %0h data %0h exp 1 2222", dbg_rvalid, dbg_rdata); end
    next_cycle();
  endtask

  task automatic test_cpu_abort();
    cpu_cs = 1; cpu_r = 1; cpu_addr = 16'h0100;
    next_cycle(); idle(); #2;
    checks++; if (cpu_ready !== 1'b0 || mem_cs !== 1'b0) begin errors++; $display("FAIL ab_discard got rdy %0h cs %0h exp 0 0", cpu_ready, mem_cs); end
    next_cycle();
    cpu_cs = 1; cpu_addr = 16'h0200; cpu_wr = 2'b01; #2;
    checks++; if (cpu_ready !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL ab_next got rdy %0h addr %0h exp 1 0200", cpu_ready, mem_addr); end
    next_cycle(); idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dbg_cs = 1; dbg_wr = 2'b01; dbg_addr = 16'h0080;
    next_cycle(); next_cycle(); idle();
    cpu_cs = 1; cpu_r = 1; cpu_addr = 16'h0008; #2;
    checks++; if (dbg_ovf !== 1'b1 || mem_addr !== 16'h0008) begin errors++; $display("FAIL rm_setup got ovf %0h addr %0h exp 1 0008", dbg_ovf, mem_addr); end
    next_cycle(); nreset = 0; #2;
    checks++; if (cpu_ready !== 1'b0 || mem_cs !== 1'b0) begin errors++; $display("FAIL rm_in_reset got rdy %0h cs %0h exp 0 0", cpu_ready, mem_cs); end
    next_cycle(); nreset = 1; cpu_addr = 16'h000A; #2;
    checks++; if (dbg_ovf !== 1'b0 || dbg_busy !== 1'b0) begin errors++; $display("FAIL rm_cleared got ovf %0h busy %0h exp 0 0", dbg_ovf, dbg_busy); end
    checks++; if (cpu_ready !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 16'h000A) begin errors++; $display("FAIL rm_fresh got rdy %0h cs %0h addr %0h exp 0 1 000a", cpu_ready, mem_cs, mem_addr); end
    next_cycle(); #2;
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hC3C9) begin errors++; $display("FAIL rm_fresh_data got rdy %0h data %0h exp 1 c3c9", cpu_ready, cpu_rdata); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rm_no_rvalid got %0h exp 0", dbg_rvalid); end
    next_cycle(); idle();
  endtask

  initial begin
    idle();
    nreset = 0;
    test_reset();
    test_cpu_write();
    test_dbg_read();
    test_contest();
    test_ovf();
    test_back_to_back();
    test_cpu_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
